// File: rtl/seq_builder_if.sv
// Handshake and sequence bus between a game controller (master) and seq_builder (slave).
interface seq_builder_if #(
  parameter int N = 64
);
  logic         start;
  logic         next;
  logic [N-1:0] data_o;
  logic         E_o;
  logic [4:0]   round_o;
  logic         busy_o;
  logic         full_o;

  modport master (
    output start, next,
    input  data_o, E_o, round_o, busy_o, full_o
  );

  modport slave (
    input  start, next,
    output data_o, E_o, round_o, busy_o, full_o
  );
endinterface

// File: rtl/seq_builder.sv
// Builds a random one-hot colour sequence one step per round from a free-running LFSR.
// Define SEQ_BUILDER_NO_REPEAT_EN to rotate a colour that would repeat the previous step.
module seq_builder #(
  parameter int          N    = 64,
  parameter int          W    = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         CLK,
  input  logic         R,
  seq_builder_if.slave bus
);

  localparam int          STEPS    = N / W;
  localparam logic [4:0]  STEPS_L  = 5'(STEPS);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
`ifdef SEQ_BUILDER_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WRITE,
    WAIT,
    FULL
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic [4:0]   round_q, round_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [W-1:0] raw_colour;
  logic [W-1:0] prev_colour;
  logic [W-1:0] colour;

  // Previous step is read back from the packed word so no extra history register is needed.
  always_comb begin
    raw_colour  = W'(1) << lfsr_q[1:0];
    prev_colour = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (5'(k) + 5'd1 == round_q) begin
        prev_colour = data_q[N-1-W*k -: W];
      end
    end
    if (NO_REPEAT && (round_q != 5'd0) && (raw_colour == prev_colour)) begin
      colour = {raw_colour[W-2:0], raw_colour[W-1]};
    end else begin
      colour = raw_colour;
    end
  end

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d = state_q;
    data_d  = data_q;
    round_d = round_q;

    if (bus.start) begin
      data_d  = '0;
      round_d = 5'd0;
      state_d = GEN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        GEN: begin
          for (int k = 0; k < STEPS; k++) begin
            if (5'(k) == round_q) begin
              data_d[N-1-W*k -: W] = colour;
            end
          end
          round_d = round_q + 5'd1;
          state_d = WRITE;
        end
        WRITE: state_d = (round_q < STEPS_L) ? WAIT : FULL;
        WAIT: begin
          if (bus.next) begin
            state_d = GEN;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q <= IDLE;
      data_q  <= '0;
      round_q <= 5'd0;
      lfsr_q  <= SEED_EFF;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.round_o = round_q;
  assign bus.E_o     = (state_q == WRITE);
  assign bus.busy_o  = (state_q == GEN) || (state_q == WRITE);
  assign bus.full_o  = (state_q == FULL);

endmodule

// File: tb/tb_seq_builder.sv
// Directed self-checking bench for seq_builder with an independent LFSR reference model.
module tb_seq_builder;

`ifdef SEQ_BUILDER_NO_REPEAT_EN
  localparam bit NO_REP = 1'b1;
`else
  localparam bit NO_REP = 1'b0;
`endif

  logic CLK;
  logic R;
  int   n_checks;
  int   n_fail;
  int   e_count;
  logic [15:0] m;
  logic [63:0] exp_data;

  seq_builder_if #(.N(64)) bus ();

  seq_builder #(.N(64), .W(4), .SEED(16'hACE1)) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] lstep(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] colour_of(logic [15:0] l);
    logic [3:0] c;
    case (l[1:0])
      2'b00:   c = 4'b0001;
      2'b01:   c = 4'b0010;
      2'b10:   c = 4'b0100;
      default: c = 4'b1000;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] expect_step(logic [3:0] raw, logic [3:0] prev, int k);
    if (NO_REP && k > 0 && raw == prev) return {raw[2:0], raw[3]};
    return raw;
  endfunction

  // Reference LFSR follows the same reset and advance rule as the block.
  always @(posedge CLK) begin
    if (!R) m <= 16'hACE1;
    else    m <= lstep(m);
  end

  always @(posedge CLK) begin
    if (bus.E_o === 1'b1) e_count <= e_count + 1;
  end

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    R = 1'b0;
    bus.start = 1'b0;
    bus.next  = 1'b0;
    repeat (3) cyc();
    R = 1'b1;
    n_checks++; if (bus.data_o !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", bus.data_o); end
    n_checks++; if (bus.round_o !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_round: got %0d expected 0", bus.round_o); end
    n_checks++; if (bus.E_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_E: got %b expected 0", bus.E_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
    n_checks++; if (bus.full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full_o); end
    n_checks++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("[TB] FAIL reset_lfsr: got %h expected ace1", dut.lfsr_q); end
    cyc();
    n_checks++; if (bus.busy_o !== 1'b0 || bus.E_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_quiet: got busy %b E %b expected 0 0", bus.busy_o, bus.E_o); end
  endtask

  task automatic test_start();
    logic [3:0] c;
    int e0;
    e0 = e_count;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    c = colour_of(m);
    n_checks++; if (bus.E_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL start_gen: got E %b busy %b expected 0 1", bus.E_o, bus.busy_o); end
    cyc();
    n_checks++; if (bus.E_o !== 1'b1) begin n_fail++; $display("[TB] FAIL start_E: got %b expected 1", bus.E_o); end
    n_checks++; if (bus.round_o !== 5'd1) begin n_fail++; $display("[TB] FAIL start_round: got %0d expected 1", bus.round_o); end
    n_checks++; if (bus.data_o[63:60] !== c) begin n_fail++; $display("[TB] FAIL start_step0: got %b expected %b", bus.data_o[63:60], c); end
    n_checks++; if (bus.data_o[59:0] !== 60'h0) begin n_fail++; $display("[TB] FAIL start_rest: got %h expected 0", bus.data_o[59:0]); end
    cyc();
    n_checks++; if (bus.E_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL start_wait: got E %b busy %b expected 0 0", bus.E_o, bus.busy_o); end
    n_checks++; if (e_count - e0 !== 1) begin n_fail++; $display("[TB] FAIL start_pulses: got %0d expected 1", e_count - e0); end
  endtask

  task automatic test_fill();
    logic [3:0] raw;
    logic [3:0] st;
    int e0;
    e0 = e_count;
    exp_data = 64'h0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) bus.start = 1'b1;
      else        bus.next  = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.next  = 1'b0;
      raw = colour_of(m);
      st  = (k == 0) ? raw : expect_step(raw, exp_data[63-4*(k-1) -: 4], k);
      exp_data[63-4*k -: 4] = st;
      n_checks++; if (bus.E_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_gen%0d: got E %b busy %b expected 0 1", k, bus.E_o, bus.busy_o); end
      cyc();
      n_checks++; if (bus.E_o !== 1'b1 || bus.round_o !== 5'(k + 1)) begin n_fail++; $display("[TB] FAIL fill_write%0d: got E %b round %0d expected 1 %0d", k, bus.E_o, bus.round_o, k + 1); end
      n_checks++; if (bus.data_o !== exp_data) begin n_fail++; $display("[TB] FAIL fill_data%0d: got %h expected %h", k, bus.data_o, exp_data); end
      cyc();
    end
    n_checks++; if (bus.full_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_full: got full %b busy %b expected 1 0", bus.full_o, bus.busy_o); end
    n_checks++; if (bus.round_o !== 5'd16) begin n_fail++; $display("[TB] FAIL fill_round: got %0d expected 16", bus.round_o); end
    bus.next = 1'b1;
    cyc();
    bus.next = 1'b0;
    repeat (3) cyc();
    n_checks++; if (e_count - e0 !== 16) begin n_fail++; $display("[TB] FAIL fill_pulses: got %0d expected 16", e_count - e0); end
    n_checks++; if (bus.full_o !== 1'b1 || bus.round_o !== 5'd16 || bus.data_o !== exp_data) begin n_fail++; $display("[TB] FAIL full_hold: got full %b round %0d data %h expected 1 16 %h", bus.full_o, bus.round_o, bus.data_o, exp_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] c;
    int e0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    e0 = e_count;
    bus.next = 1'b1;
    cyc();
    bus.next = 1'b0;
    n_checks++; if (bus.busy_o !== 1'b0 || bus.E_o !== 1'b0) begin n_fail++; $display("[TB] FAIL write_next_wait: got busy %b E %b expected 0 0", bus.busy_o, bus.E_o); end
    cyc();
    n_checks++; if (bus.busy_o !== 1'b0 || bus.round_o !== 5'd1) begin n_fail++; $display("[TB] FAIL write_next_ignored: got busy %b round %0d expected 0 1", bus.busy_o, bus.round_o); end
    n_checks++; if (e_count - e0 !== 1) begin n_fail++; $display("[TB] FAIL write_next_pulses: got %0d expected 1", e_count - e0); end
    bus.start = 1'b1;
    bus.next  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.next  = 1'b0;
    c = colour_of(m);
    n_checks++; if (bus.round_o !== 5'd0 || bus.data_o !== 64'h0) begin n_fail++; $display("[TB] FAIL both_clear: got round %0d data %h expected 0 0", bus.round_o, bus.data_o); end
    cyc();
    n_checks++; if (bus.E_o !== 1'b1 || bus.round_o !== 5'd1) begin n_fail++; $display("[TB] FAIL both_write: got E %b round %0d expected 1 1", bus.E_o, bus.round_o); end
    n_checks++; if (bus.data_o !== {c, 60'h0}) begin n_fail++; $display("[TB] FAIL both_data: got %h expected %h", bus.data_o, {c, 60'h0}); end
    cyc();
  endtask

  task automatic test_reset_in_gen();
    int e0;
    bus.next = 1'b1;
    cyc();
    bus.next = 1'b0;
    e0 = e_count;
    n_checks++; if (bus.busy_o !== 1'b1 || bus.round_o !== 5'd1) begin n_fail++; $display("[TB] FAIL rgen_in_gen: got busy %b round %0d expected 1 1", bus.busy_o, bus.round_o); end
    R = 1'b0;
    cyc();
    R = 1'b1;
    n_checks++; if (bus.data_o !== 64'h0 || bus.round_o !== 5'd0) begin n_fail++; $display("[TB] FAIL rgen_clear: got data %h round %0d expected 0 0", bus.data_o, bus.round_o); end
    n_checks++; if (bus.busy_o !== 1'b0 || bus.E_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rgen_idle: got busy %b E %b expected 0 0", bus.busy_o, bus.E_o); end
    repeat (3) cyc();
    n_checks++; if (e_count - e0 !== 0) begin n_fail++; $display("[TB] FAIL rgen_pulses: got %0d expected 0", e_count - e0); end
    n_checks++; if (dut.lfsr_q !== m) begin n_fail++; $display("[TB] FAIL lfsr_track: got %h expected %h", dut.lfsr_q, m); end
  endtask

  task automatic test_no_repeat();
    bit found;
    logic [3:0] exp1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (colour_of(lstep(m)) == 4'b0100) found = 1'b1;
      else cyc();
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL norep_find0: got none expected 0100 within 200 cycles"); end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    n_checks++; if (bus.data_o[63:60] !== 4'b0100) begin n_fail++; $display("[TB] FAIL norep_step0: got %b expected 0100", bus.data_o[63:60]); end
    cyc();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (colour_of(lstep(m)) == 4'b0100) found = 1'b1;
      else cyc();
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL norep_find1: got none expected 0100 within 200 cycles"); end
    bus.next = 1'b1;
    cyc();
    bus.next = 1'b0;
    cyc();
    exp1 = NO_REP ? 4'b1000 : 4'b0100;
    n_checks++; if (bus.E_o !== 1'b1 || bus.data_o[59:56] !== exp1) begin n_fail++; $display("[TB] FAIL norep_step1: got E %b step %b expected 1 %b", bus.E_o, bus.data_o[59:56], exp1); end
    cyc();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    e_count   = 0;
    R         = 1'b0;
    bus.start = 1'b0;
    bus.next  = 1'b0;
    @(negedge CLK);
    $display("[TB] seq_builder directed test starting");
    test_reset();
    test_start();
    test_fill();
    test_back_to_back();
    test_reset_in_gen();
    test_no_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
